obj_line_scanner: RTL and testbench

- Reader side of the painter object list. Replaces per-pixel evaluation of the full packed array with a scanline flow.
- During each horizontal blank it walks the object list, one entry per clock, and latches the objects that intersect the next video line into a small active set.
- During active video it composites only that active set into pix_data.
- Sits between painter (obj_arr_packed, arr_len) and vga_driver (pix_x, pix_y, pix_data), clocked by vga_clk.

---
 rtl/obj_pkg.sv | 47 ++++
 rtl/obj_hit_test.sv | 34 +++
 rtl/obj_line_scanner.sv | 199 +++++++++++++++++++
 tb/tb_obj_line_scanner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared definitions for the scanline object renderer: field layout, object types, colours, VGA timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obj_pkg;

    // VGA 640x480@60 timing in pixel-clock units
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    // Object entry field positions (LSB of each field)
    localparam int OBJ_TYPE_LSB = 52;
    localparam int OBJ_X_LSB    = 42;
    localparam int OBJ_Y_LSB    = 32;
    localparam int OBJ_W_LSB    = 22;
    localparam int OBJ_H_LSB    = 12;
    localparam int OBJ_COL_LSB  = 0;

    typedef enum logic [3:0] {
        OBJ_RECT   = 4'd0,
        OBJ_CIRCLE = 4'd1
    } obj_type_e;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_WHITE = 12'hFFF;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_GREEN = 12'h0F0;
    localparam logic [11:0] COL_BLUE  = 12'h00F;

    // One retained object for the current line. For a circle, budget holds
    // r^2 - dy^2 so the per-pixel test only needs the horizontal term.
    typedef struct packed {
        logic        is_circle;
        logic [9:0]  x;
        logic [9:0]  w;
        logic [20:0] budget;
        logic [11:0] colour;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } scan_state_e;

endpackage

// File: rtl/obj_hit_test.sv
// Horizontal hit test of one pixel column against one retained slot.
// Latency: combinational.
// Backpressure: none.
module obj_hit_test
    import obj_pkg::*;
(
    input  logic [9:0] pix_x_i,
    input  slot_t      slot_i,
    output logic       hit_o
);

    logic [10:0]        px_ext;
    logic [10:0]        x_ext;
    logic [10:0]        x_end;
    logic signed [10:0] dx;
    logic [9:0]         adx;
    logic [20:0]        dx_sq;

    // Rectangle: span compare in 11 bits; circle: dx^2 against the stored budget
    always_comb begin
        px_ext = {1'b0, pix_x_i};
        x_ext  = {1'b0, slot_i.x};
        x_end  = x_ext + {1'b0, slot_i.w};
        dx     = $signed(px_ext) - $signed(x_ext);
        adx    = dx[10] ? 10'(-dx) : dx[9:0];
        dx_sq  = {11'b0, adx} * {11'b0, adx};
        if (slot_i.is_circle) begin
            hit_o = (dx_sq <= slot_i.budget);
        end else begin
            hit_o = (x_ext <= px_ext) && (px_ext < x_end);
        end
    end

endmodule

// File: rtl/obj_line_scanner.sv
// Scans the object list during h-blank into a small per-line active set, composites that set during video.
// Latency: pix_data is registered, one cycle after pix_x/pix_y; the active set changes at pix_x == H_TOTAL-1.
// Backpressure: none; follows the free-running pixel counters, excess hits on a line are dropped and flagged.
module obj_line_scanner
    import obj_pkg::*;
#(
    parameter int OBJ_WIDTH  = 56,
    parameter int MAX_LEN    = 16,
    parameter int MAX_ACTIVE = 4,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_TOTAL    = VGA_V_TOTAL
) (
    input  logic                          vga_clk,
    input  logic                          rst,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic [OBJ_WIDTH*MAX_LEN-1:0]  obj_arr_packed,
    input  logic [5:0]                    obj_arr_len,
    output logic [11:0]                   pix_data,
    output logic                          scan_busy,
    output logic                          line_overflow
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(MAX_ACTIVE + 1);

    scan_state_e   state_q;
    logic [IW-1:0] k_q;
    logic [9:0]    tgt_q;
    logic [CW-1:0] shadow_cnt_q;
    logic [CW-1:0] act_cnt_q;
    logic          ovf_q;
    logic          line_ovf_q;
    logic          busy_q;
    logic [11:0]   pix_q;
    slot_t         shadow_q [MAX_ACTIVE];
    slot_t         act_q    [MAX_ACTIVE];

    logic [9:0]    tgt_d;
    logic [7:0]    len_ext;
    logic [7:0]    eff_len;
    logic [IW-1:0] k_init;

    logic [OBJ_WIDTH-1:0] entry;
    logic [3:0]           e_type;
    logic [9:0]           e_x, e_y, e_w, e_h;
    logic [11:0]          e_col;
    logic [10:0]          t_ext, y_ext;
    logic signed [10:0]   dy;
    logic [9:0]           ady;
    logic [20:0]          r_sq, dy_sq;
    logic                 rect_hit, circ_hit, scan_hit;
    slot_t                new_slot;

    logic [MAX_ACTIVE-1:0] slot_hit;
    logic [11:0]           pix_d;

    assign tgt_d   = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
    assign len_ext = {2'b00, obj_arr_len};
    assign eff_len = (len_ext > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len_ext;
    assign k_init  = IW'(eff_len - 8'd1);

    // Only the entry under the scan index is read, one per clock
    assign entry  = obj_arr_packed[int'(k_q) * OBJ_WIDTH +: OBJ_WIDTH];
    assign e_type = entry[OBJ_TYPE_LSB +: 4];
    assign e_x    = entry[OBJ_X_LSB +: 10];
    assign e_y    = entry[OBJ_Y_LSB +: 10];
    assign e_w    = entry[OBJ_W_LSB +: 10];
    assign e_h    = entry[OBJ_H_LSB +: 10];
    assign e_col  = entry[OBJ_COL_LSB +: 12];

    // Vertical intersection of the scanned entry with the target line, and the slot it would occupy
    always_comb begin
        t_ext    = {1'b0, tgt_q};
        y_ext    = {1'b0, e_y};
        dy       = $signed(t_ext) - $signed(y_ext);
        ady      = dy[10] ? 10'(-dy) : dy[9:0];
        r_sq     = {11'b0, e_w} * {11'b0, e_w};
        dy_sq    = {11'b0, ady} * {11'b0, ady};
        rect_hit = (e_type == OBJ_RECT) && (y_ext <= t_ext) && (t_ext < y_ext + {1'b0, e_h});
        circ_hit = (e_type == OBJ_CIRCLE) && (ady <= e_w);
        scan_hit = rect_hit || circ_hit;
        new_slot.is_circle = (e_type == OBJ_CIRCLE);
        new_slot.x         = e_x;
        new_slot.w         = e_w;
        new_slot.budget    = (e_type == OBJ_CIRCLE) ? (r_sq - dy_sq) : 21'd0;
        new_slot.colour    = e_col;
    end

    // Scan FSM: fills the shadow set during blank, swaps it in at the last pixel of the line
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            tgt_q        <= '0;
            shadow_cnt_q <= '0;
            act_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            line_ovf_q   <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
        end else if (pix_x == 10'(H_TOTAL - 1)) begin
            // Commit wins over a scan still in flight; shadow is emptied so a
            // line without a scan commits an empty set next time.
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                act_q[i] <= shadow_q[i];
            end
            act_cnt_q    <= shadow_cnt_q;
            line_ovf_q   <= ovf_q;
            shadow_cnt_q <= '0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pix_x == 10'(H_ACTIVE) && tgt_d < 10'(V_ACTIVE)) begin
                        shadow_cnt_q <= '0;
                        ovf_q        <= 1'b0;
                        tgt_q        <= tgt_d;
                        k_q          <= k_init;
                        if (eff_len == 8'd0) begin
                            state_q <= ST_HOLD;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SCAN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        if (shadow_cnt_q < CW'(MAX_ACTIVE)) begin
                            for (int i = 0; i < MAX_ACTIVE; i++) begin
                                if (CW'(i) == shadow_cnt_q) begin
                                    shadow_q[i] <= new_slot;
                                end
                            end
                            shadow_cnt_q <= shadow_cnt_q + CW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    if (k_q == '0) begin
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q <= k_q - IW'(1);
                    end
                end
                ST_HOLD: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_hit
        obj_hit_test u_hit (
            .pix_x_i (pix_x),
            .slot_i  (act_q[g]),
            .hit_o   (slot_hit[g])
        );
    end

    // Lowest occupied slot (highest list index) wins; black outside the visible area
    always_comb begin
        pix_d = COL_BLACK;
        if (pix_x < 10'(H_ACTIVE) && pix_y < 10'(V_ACTIVE)) begin
            for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
                if (slot_hit[i] && (CW'(i) < act_cnt_q)) begin
                    pix_d = act_q[i].colour;
                end
            end
        end
    end

    // Register the composited colour
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            pix_q <= COL_BLACK;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_data      = pix_q;
    assign scan_busy     = busy_q;
    assign line_overflow = line_ovf_q;

endmodule

// File: tb/tb_obj_line_scanner.sv
// Bench for obj_line_scanner: directed scanlines plus randomized object lists against a per-line reference model.
// Latency: checks pix_data one cycle after pix_x/pix_y, scan_busy and line_overflow after every edge.
// Backpressure: none.
module tb_obj_line_scanner;

    localparam int OW = 56;
    localparam int ML = 16;
    localparam int MA = 4;

    typedef struct {
        int t;
        int x;
        int y;
        int w;
        int h;
        int col;
    } obj_m_t;

    logic               vga_clk = 1'b0;
    logic               rst;
    logic [9:0]         pix_x;
    logic [9:0]         pix_y;
    logic [OW*ML-1:0]   obj_arr_packed;
    logic [5:0]         obj_arr_len;
    logic [11:0]        pix_data;
    logic               scan_busy;
    logic               line_overflow;

    int checks = 0;
    int errors = 0;
    int cur_x  = 0;
    int cur_y  = 0;

    // painter-side list
    obj_m_t objs [ML];
    int     len;

    // reference model: committed set for the displayed line and the set built during this line's blank
    obj_m_t disp [$];
    int     disp_t;
    int     disp_ovf;
    obj_m_t pend [$];
    int     pend_t;
    int     pend_ovf;
    int     pend_valid;
    int     pend_len;
    int     exp_pix, exp_busy, exp_ovf;
    int     busy_seen;

    obj_line_scanner dut (
        .vga_clk        (vga_clk),
        .rst            (rst),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .obj_arr_packed (obj_arr_packed),
        .obj_arr_len    (obj_arr_len),
        .pix_data       (pix_data),
        .scan_busy      (scan_busy),
        .line_overflow  (line_overflow)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s x=%0d y=%0d got=%0h want=%0h", tag, cur_x, cur_y, got, want);
        end
    endtask

    function automatic logic [OW-1:0] mk(input obj_m_t o);
        logic [OW-1:0] e;
        e = {o.t[3:0], o.x[9:0], o.y[9:0], o.w[9:0], o.h[9:0], o.col[11:0]};
        return e;
    endfunction

    task automatic apply_objs();
        for (int i = 0; i < ML; i++) obj_arr_packed[i*OW +: OW] = mk(objs[i]);
        obj_arr_len = 6'(len);
    endtask

    task automatic clear_objs();
        for (int i = 0; i < ML; i++) objs[i] = '{t: 15, x: 0, y: 0, w: 0, h: 0, col: 0};
        len = 0;
    endtask

    // geometric intersection of object o with line t
    function automatic bit on_line(input obj_m_t o, input int t);
        int d;
        d = (t > o.y) ? t - o.y : o.y - t;
        if (o.t == 0) return (o.y <= t) && (t < o.y + o.h);
        if (o.t == 1) return d <= o.w;
        return 0;
    endfunction

    // colour of pixel px given the committed set; highest index first
    function automatic int pix_model(input int px);
        foreach (disp[j]) begin
            if (disp[j].t == 0 && px >= disp[j].x && px < disp[j].x + disp[j].w) return disp[j].col;
            if (disp[j].t == 1 && (px - disp[j].x) * (px - disp[j].x) + (disp_t - disp[j].y) * (disp_t - disp[j].y)
                                  <= disp[j].w * disp[j].w) return disp[j].col;
        end
        return 0;
    endfunction

    task automatic model_reset();
        disp.delete();
        pend.delete();
        disp_ovf   = 0;
        pend_valid = 0;
        pend_ovf   = 0;
        pend_len   = 0;
    endtask

    // expected state after one clock edge that sampled (x, y)
    task automatic model_edge(input int x, input int y);
        int t, n;
        exp_pix = (x < 640 && y < 480) ? pix_model(x) : 0;
        t = (y == 524) ? 0 : y + 1;
        if (x == 799) begin
            disp.delete();
            if (pend_valid) begin
                foreach (pend[j]) disp.push_back(pend[j]);
                disp_t   = pend_t;
                disp_ovf = pend_ovf;
            end else begin
                disp_ovf = 0;
            end
            pend_valid = 0;
        end else if (x == 640 && t < 480) begin
            n = (len > ML) ? ML : len;
            pend.delete();
            pend_ovf = 0;
            pend_t   = t;
            for (int i = n - 1; i >= 0; i--) begin
                if (on_line(objs[i], t)) begin
                    if (pend.size() < MA) pend.push_back(objs[i]);
                    else pend_ovf = 1;
                end
            end
            pend_valid = 1;
            pend_len   = n;
        end
        exp_busy = (pend_valid != 0 && x >= 640 && x < 640 + pend_len) ? 1 : 0;
        exp_ovf  = disp_ovf;
    endtask

    task automatic drive_cycle(input int x, input int y, input logic rst_v);
        @(negedge vga_clk);
        if (!rst_v && rst) begin
            rst = 1'b0;
            #1;
            check("rst_pix", 32'(pix_data), 32'h0);
            check("rst_busy", 32'(scan_busy), 32'h0);
            check("rst_ovf", 32'(line_overflow), 32'h0);
            model_reset();
        end else if (rst_v) begin
            rst = 1'b1;
        end
        pix_x = 10'(x);
        pix_y = 10'(y);
        cur_x = x;
        cur_y = y;
        @(posedge vga_clk);
        if (rst) begin
            model_edge(x, y);
        end else begin
            exp_pix = 0; exp_busy = 0; exp_ovf = 0;
        end
        #5;
        if (scan_busy === 1'b1) busy_seen++;
        check("pix", 32'(pix_data), 32'(exp_pix));
        check("busy", 32'(scan_busy), 32'(exp_busy));
        check("ovf", 32'(line_overflow), 32'(exp_ovf));
    endtask

    task automatic run_line(input int y, input int rlo, input int rhi);
        busy_seen = 0;
        for (int x = 0; x < 800; x++) drive_cycle(x, y, !(x >= rlo && x < rhi));
    endtask

    task automatic line(input int y);
        run_line(y, -1, -1);
    endtask

    initial begin
        rst = 1'b0;
        pix_x = '0;
        pix_y = '0;
        obj_arr_packed = '0;
        obj_arr_len = '0;
        clear_objs();
        model_reset();
        disp_t = 0;
        pend_t = 0;
        repeat (3) @(negedge vga_clk);
        check("reset_pix", 32'(pix_data), 32'h0);
        check("reset_busy", 32'(scan_busy), 32'h0);
        check("reset_ovf", 32'(line_overflow), 32'h0);
        rst = 1'b1;

        // single white rectangle
        clear_objs();
        objs[0] = '{t: 0, x: 100, y: 100, w: 50, h: 20, col: 'hFFF};
        len = 1;
        apply_objs();
        line(98); line(99); line(100); line(119); line(120);

        // green circle, r=10
        clear_objs();
        objs[0] = '{t: 1, x: 200, y: 200, w: 10, h: 0, col: 'h0F0};
        len = 1;
        apply_objs();
        line(199); line(200); line(209); line(210); line(211);

        // same geometry, higher index must win
        clear_objs();
        objs[0] = '{t: 0, x: 300, y: 10, w: 40, h: 5, col: 'hF00};
        objs[1] = '{t: 0, x: 300, y: 10, w: 40, h: 5, col: 'h00F};
        len = 2;
        apply_objs();
        line(9); line(10);

        // six rectangles on line 50: only 5..2 retained, overflow flagged
        clear_objs();
        for (int i = 0; i < 6; i++) objs[i] = '{t: 0, x: 20 * i, y: 40, w: 100, h: 15, col: 16 * i + 1};
        len = 6;
        apply_objs();
        line(49); line(50); line(59); line(60);

        // empty list: no scan body
        clear_objs();
        len = 0;
        apply_objs();
        line(10);
        check("len0_busy_cycles", 32'(busy_seen), 32'd0);
        line(11);

        // oversized length clamps to the array size
        for (int i = 0; i < ML; i++) objs[i] = '{t: 0, x: 30 * i, y: 290, w: 25, h: 20, col: 'h123 + i};
        len = 40;
        apply_objs();
        line(300);
        check("len40_busy_cycles", 32'(busy_seen), 32'd16);
        line(301);

        // reset in the middle of a scan
        clear_objs();
        for (int i = 0; i < 6; i++) objs[i] = '{t: 0, x: 20 * i, y: 40, w: 100, h: 15, col: 16 * i + 1};
        len = 6;
        apply_objs();
        line(48);
        run_line(49, 645, 660);
        line(50); line(51);

        // vertical wrap and last visible line
        clear_objs();
        objs[0] = '{t: 0, x: 5, y: 0, w: 30, h: 3, col: 'hABC};
        objs[1] = '{t: 1, x: 600, y: 479, w: 6, h: 0, col: 'h0F0};
        len = 2;
        apply_objs();
        line(523); line(524); line(0); line(478); line(479); line(0);

        // randomized object lists
        for (int r = 0; r < 14; r++) begin
            int yl;
            yl = $urandom_range(0, 522);
            clear_objs();
            for (int i = 0; i < ML; i++) begin
                int ty;
                ty = $urandom_range(0, 9);
                objs[i].t   = (ty < 5) ? 0 : (ty < 9) ? 1 : $urandom_range(2, 15);
                objs[i].x   = $urandom_range(0, 650);
                objs[i].y   = yl + $urandom_range(0, 80) - 40;
                if (objs[i].y < 0) objs[i].y = 0;
                objs[i].w   = (objs[i].t == 1) ? $urandom_range(0, 40) : $urandom_range(0, 120);
                objs[i].h   = $urandom_range(0, 40);
                objs[i].col = $urandom_range(1, 4095);
            end
            len = $urandom_range(0, 20);
            apply_objs();
            line(yl);
            line(yl + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
